me_integer_search: RTL and testbench

- Integer-pel refinement engine; the responder end of the req_i/ack_i handshake issued by the motion-estimation controller.
- Latches a 12-bit initial position {row[5:0], col[5:0]} and evaluates SAD for a 3x3 neighbourhood (dy, dx in {-1,0,+1}).
- Reads the current block and a 64x64 reference window through two synchronous-read pixel memories.
- Returns minimum SAD and packed 2-bit signed offsets.

---
 rtl/me_integer_search.sv | 196 +++++++++++++++++++
 tb/tb_me_integer_search.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/me_integer_search.sv
// me_integer_search: integer-pel refinement engine.
// Latches a starting position and evaluates the SAD of a BLKxBLK block
// against a 3x3 neighbourhood of candidate positions. It then returns the
// minimum SAD and the winning {dy,dx} offset.
// Handshake: 4-phase req/ack. The block is the responder.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req, init_pos     start request; init_pos = {row[5:0], col[5:0]}
//   ack               results valid, held until req falls
//   min_sad, min_diff best SAD and {dy[1:0], dx[1:0]} (two's complement)
//   cur_addr/cur_data current-block memory, {y,x}; 1-cycle read latency
//   ref_addr/ref_data reference-window memory, {row,col}; 1-cycle read latency
//
// Optional feature: define ME_INT_EARLY_TERM_EN to abandon a candidate as soon
// as its partial SAD reaches the best so far. This only cuts latency. Results
// are unchanged.
module me_integer_search #(
    parameter int BLK     = 16,
    parameter int POS_MAX = 64 - BLK
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [11:0] init_pos,
    output logic        ack,
    output logic [15:0] min_sad,
    output logic [3:0]  min_diff,
    output logic [7:0]  cur_addr,
    input  logic [7:0]  cur_data,
    output logic [11:0] ref_addr,
    input  logic [7:0]  ref_data
);

    typedef enum logic [2:0] {
        IDLE, SETUP, ACCUM, DRAIN, COMPARE, DONE, WAIT_REQ_FALL
    } state_t;

    state_t state_q, state_d;

    logic [5:0]  row_q, col_q;      // latched search centre
    logic [5:0]  r_q, c_q;          // top-left of the candidate being summed
    logic [3:0]  k_q;               // candidate index 0..8
    logic [3:0]  x_q, y_q;          // pixel currently on the address bus
    logic [15:0] acc_q;
    logic [15:0] best_sad_q;
    logic [3:0]  best_diff_q;
    logic [7:0]  diff_q;            // registered |cur-ref|
    logic [1:0]  vld_pipe;          // [0]: read data returning, [1]: diff_q valid
    logic        drain_q;
    logic        et_q;              // candidate abandoned early; skip its compare

    // Candidate offsets. The centre comes first so that ties keep zero motion.
    logic signed [1:0] dy, dx;
    always_comb begin
        dy = 2'sb00;
        dx = 2'sb00;
        case (k_q)
            4'd1:    begin dy = -2'sd1; dx = -2'sd1; end
            4'd2:    begin dy = -2'sd1; dx =  2'sd0; end
            4'd3:    begin dy = -2'sd1; dx =  2'sd1; end
            4'd4:    begin dy =  2'sd0; dx = -2'sd1; end
            4'd5:    begin dy =  2'sd0; dx =  2'sd1; end
            4'd6:    begin dy =  2'sd1; dx = -2'sd1; end
            4'd7:    begin dy =  2'sd1; dx =  2'sd0; end
            4'd8:    begin dy =  2'sd1; dx =  2'sd1; end
            default: begin dy =  2'sd0; dx =  2'sd0; end
        endcase
    end

    // A negative coordinate wraps to >=8'hFE, so one unsigned bound check
    // rejects both underflow and overflow.
    logic [7:0] r_s, c_s;
    logic       cand_ok, last_k, last_x, last_pix, et_trip;
    logic [3:0] x_n, y_n;

    assign r_s      = {2'b00, row_q} + {{6{dy[1]}}, dy};
    assign c_s      = {2'b00, col_q} + {{6{dx[1]}}, dx};
    assign cand_ok  = (r_s <= 8'(POS_MAX)) && (c_s <= 8'(POS_MAX));
    assign last_k   = (k_q == 4'd8);
    assign last_x   = (x_q == 4'(BLK - 1));
    assign last_pix = last_x && (y_q == 4'(BLK - 1));
    assign x_n      = last_x ? 4'd0 : x_q + 4'd1;
    assign y_n      = last_x ? y_q + 4'd1 : y_q;

`ifdef ME_INT_EARLY_TERM_EN
    // Partial SAD, including the add landing this cycle. The SAD only grows,
    // so once it reaches best_sad this candidate cannot win.
    logic [15:0] acc_run;
    assign acc_run = acc_q + (vld_pipe[1] ? {8'd0, diff_q} : 16'd0);
    assign et_trip = (acc_run >= best_sad_q);
`else
    assign et_trip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:          if (req) state_d = SETUP;
            SETUP:         if (cand_ok)     state_d = ACCUM;
                           else if (last_k) state_d = DONE;
            ACCUM:         if (last_pix || et_trip) state_d = DRAIN;
            DRAIN:         if (drain_q) state_d = COMPARE;
            COMPARE:       state_d = last_k ? DONE : SETUP;
            DONE:          state_d = WAIT_REQ_FALL;
            WAIT_REQ_FALL: if (!req) state_d = IDLE;
            default:       state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack         <= 1'b0;
            min_sad     <= '0;
            min_diff    <= '0;
            cur_addr    <= '0;
            ref_addr    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            r_q         <= '0;
            c_q         <= '0;
            k_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            acc_q       <= '0;
            best_sad_q  <= '0;
            best_diff_q <= '0;
            diff_q      <= '0;
            vld_pipe    <= '0;
            drain_q     <= 1'b0;
            et_q        <= 1'b0;
        end else begin
            // Read pipeline: address -> data (mem) -> |diff| -> accumulate.
            vld_pipe <= {vld_pipe[0], state_q == ACCUM};
            if (vld_pipe[0])
                diff_q <= (cur_data > ref_data) ? cur_data - ref_data
                                                : ref_data - cur_data;
            if (state_q == SETUP && cand_ok) acc_q <= '0;
            else if (vld_pipe[1])            acc_q <= acc_q + {8'd0, diff_q};

            case (state_q)
                IDLE: if (req) begin
                    row_q       <= init_pos[11:6];
                    col_q       <= init_pos[5:0];
                    best_sad_q  <= 16'hFFFF;
                    best_diff_q <= '0;
                    k_q         <= '0;
                end
                SETUP: begin
                    if (cand_ok) begin
                        r_q      <= r_s[5:0];
                        c_q      <= c_s[5:0];
                        x_q      <= '0;
                        y_q      <= '0;
                        cur_addr <= '0;
                        ref_addr <= {r_s[5:0], c_s[5:0]};
                        drain_q  <= 1'b0;
                        et_q     <= 1'b0;
                    end else if (!last_k) begin
                        k_q <= k_q + 4'd1;
                    end
                end
                ACCUM: begin
                    et_q <= et_trip;
                    if (!(last_pix || et_trip)) begin
                        x_q      <= x_n;
                        y_q      <= y_n;
                        cur_addr <= {y_n, x_n};
                        ref_addr <= {r_q + {2'b00, y_n}, c_q + {2'b00, x_n}};
                    end
                end
                DRAIN: drain_q <= 1'b1;
                COMPARE: begin
                    if (!et_q && acc_q < best_sad_q) begin
                        best_sad_q  <= acc_q;
                        best_diff_q <= {dy, dx};
                    end
                    if (!last_k) k_q <= k_q + 4'd1;
                end
                DONE: begin
                    min_sad  <= best_sad_q;
                    min_diff <= best_diff_q;
                    ack      <= 1'b1;
                end
                WAIT_REQ_FALL: if (!req) ack <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_me_integer_search.sv
module tb_me_integer_search;

    localparam int BLK     = 4;
    localparam int POS_MAX = 64 - BLK;

    logic        clk, rst_n, req, ack;
    logic [11:0] init_pos, ref_addr;
    logic [15:0] min_sad;
    logic [3:0]  min_diff;
    logic [7:0]  cur_addr, cur_data, ref_data;

    me_integer_search #(.BLK(BLK)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .init_pos(init_pos),
        .ack(ack), .min_sad(min_sad), .min_diff(min_diff),
        .cur_addr(cur_addr), .cur_data(cur_data),
        .ref_addr(ref_addr), .ref_data(ref_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read pixel memories
    logic [7:0] cur_mem [256];
    logic [7:0] ref_mem [4096];
    always @(posedge clk) begin
        cur_data <= cur_mem[cur_addr];
        ref_data <= ref_mem[ref_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int sad;
        int diff;
        int due;
        int width;
    } exp_t;
    exp_t exp_q[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference model: straightforward search over the 9 offsets.
    task automatic model(input logic [11:0] pos, output int sad, output int diff,
                         output int lat);
        int dys[9];
        int dxs[9];
        int nvalid, r, c, s, a, b;
        logic [1:0] dyb, dxb;
        dys = '{0, -1, -1, -1, 0, 0, 1, 1, 1};
        dxs = '{0, -1, 0, 1, -1, 1, -1, 0, 1};
        sad = 65535;
        diff = 0;
        nvalid = 0;
        for (int k = 0; k < 9; k++) begin
            r = int'(pos[11:6]) + dys[k];
            c = int'(pos[5:0]) + dxs[k];
            if (r >= 0 && c >= 0 && r <= POS_MAX && c <= POS_MAX) begin
                nvalid++;
                s = 0;
                for (int y = 0; y < BLK; y++)
                    for (int x = 0; x < BLK; x++) begin
                        a = int'(cur_mem[y*16+x]);
                        b = int'(ref_mem[(r+y)*64 + c + x]);
                        s += (a > b) ? a - b : b - a;
                    end
                if (s < sad) begin
                    sad = s;
                    dyb = dys[k][1:0];
                    dxb = dxs[k][1:0];
                    diff = int'({dyb, dxb});
                end
            end
        end
        lat = nvalid * (BLK*BLK + 4) + (9 - nvalid) + 1;
    endtask

    task automatic fill_rand(input int maxv);
        for (int i = 0; i < 256; i++)  cur_mem[i] = 8'($urandom_range(maxv, 0));
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'($urandom_range(maxv, 0));
    endtask

    task automatic plant(input int r, input int c);
        for (int y = 0; y < BLK; y++)
            for (int x = 0; x < BLK; x++)
                ref_mem[(r+y)*64 + c + x] = cur_mem[y*16+x];
    endtask

    // Issue one request. hold = extra cycles req stays high after ack is seen.
    // drop = release req 5 cycles after start.
    task automatic run_txn(input logic [11:0] pos, input int hold, input bit drop);
        exp_t e;
        int lat, n;
        @(negedge clk);
        model(pos, e.sad, e.diff, lat);
        e.due   = cyc + 1 + lat;
        e.width = drop ? 1 : hold + 1;
        exp_q.push_back(e);
        req = 1'b1;
        init_pos = pos;
        if (drop) begin
            repeat (5) @(negedge clk);
            req = 1'b0;
        end
        n = 0;
        while (!ack && n < 3000) begin @(negedge clk); n++; end
        check("ack_rise_timeout", int'(ack), 1);
        if (!drop) begin
            repeat (hold) @(negedge clk);
            req = 1'b0;
        end
        n = 0;
        while (ack && n < 50) begin @(negedge clk); n++; end
        check("ack_fall_timeout", int'(ack), 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pops the expected result on every rising ack.
    initial begin
        exp_t cur;
        bit   have, ack_q;
        int   rise;
        have = 0; ack_q = 0; rise = 0;
        forever begin
            @(negedge clk);
            if (ack && !ack_q) begin
                rise = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                    have = 0;
                end else begin
                    cur = exp_q.pop_front();
                    have = 1;
                    check("min_sad", int'(min_sad), cur.sad);
                    check("min_diff", int'(min_diff), cur.diff);
                    check("ack_cycle", rise, cur.due);
                end
            end
            if (!ack && ack_q && have) begin
                check("ack_width", cyc - rise, cur.width);
                have = 0;
            end
            ack_q = ack;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req = 1'b0;
        init_pos = '0;
        fill_rand(255);
        repeat (3) @(negedge clk);
        check("rst_ack", int'(ack), 0);
        check("rst_min_sad", int'(min_sad), 0);
        check("rst_min_diff", int'(min_diff), 0);
        check("rst_cur_addr", int'(cur_addr), 0);
        check("rst_ref_addr", int'(ref_addr), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Unique exact match at (11,9), every other pixel off by one
        for (int i = 0; i < 256; i++)  cur_mem[i] = 8'd100;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd101;
        for (int r = 11; r < 11 + BLK; r++)
            for (int c = 9; c < 9 + BLK; c++) ref_mem[r*64+c] = 8'd100;
        run_txn({6'd10, 6'd10}, 0, 0);

        // Flat data: every SAD equals 16, the centre must win
        for (int i = 0; i < 256; i++)  cur_mem[i] = 8'd50;
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'd51;
        run_txn({6'd20, 6'd30}, 2, 0);

        // Corner start with the match at (1,1)
        fill_rand(255);
        plant(1, 1);
        run_txn({6'd0, 6'd0}, 1, 0);

        // Everything out of range
        run_txn({6'd63, 6'd63}, 0, 0);

        // req dropped mid-search, then a normal follow-up
        fill_rand(255);
        run_txn({6'd30, 6'd31}, 0, 1);
        run_txn({6'd5, 6'd40}, 1, 0);

        // Reset in the middle of ACCUM
        @(negedge clk);
        req = 1'b1;
        init_pos = {6'd20, 6'd20};
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ack", int'(ack), 0);
        check("abort_min_sad", int'(min_sad), 0);
        check("abort_min_diff", int'(min_diff), 0);
        check("abort_cur_addr", int'(cur_addr), 0);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_txn({6'd20, 6'd20}, 0, 0);

        // Randomized runs: edge/interior positions, wide or narrow pixel range
        for (int t = 0; t < 12; t++) begin
            int edges[6];
            logic [5:0] r6, c6;
            edges = '{0, 1, 59, 60, 61, 63};
            fill_rand(($urandom_range(1, 0) == 0) ? 3 : 255);
            r6 = ($urandom_range(2, 0) == 0) ? 6'(edges[$urandom_range(5, 0)])
                                             : 6'($urandom_range(63, 0));
            c6 = ($urandom_range(2, 0) == 0) ? 6'(edges[$urandom_range(5, 0)])
                                             : 6'($urandom_range(63, 0));
            if ($urandom_range(1, 0) == 1 && r6 >= 1 && c6 >= 1 && r6 <= 59 && c6 <= 59)
                plant(int'(r6) + $urandom_range(2, 0) - 1, int'(c6) + $urandom_range(2, 0) - 1);
            run_txn({r6, c6}, $urandom_range(3, 0), $urandom_range(3, 0) == 0);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
